// File: rtl/max_pool_pkg.sv
// rtl/max_pool_pkg.sv - shared data width, sample type, FSM encoding and width helper for max_pool_2d
package max_pool_pkg;

  localparam int DATA_W = 16;

  typedef logic signed [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter/address width that never collapses to zero bits for degenerate sizes.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pool_addr_gen.sv
// rtl/pool_addr_gen.sv - channel/oy/ox/window counters for max_pool_2d: registered read
// address, output (window) index and first/last-element and last-window flags.
module pool_addr_gen
  import max_pool_pkg::*;
#(
  parameter int W  = 62,
  parameter int H  = 62,
  parameter int C  = 30,
  parameter int S  = 2,
  parameter int IA = 17,
  parameter int OA = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          advance,
  output logic [IA-1:0] input_addr,
  output logic [OA-1:0] win_addr,
  output logic          first_elem,
  output logic          last_elem,
  output logic          last_win
);

  localparam int OW = W / S;
  localparam int OH = H / S;
  localparam int CW = cnt_w(C);
  localparam int YW = cnt_w(OH);
  localparam int XW = cnt_w(OW);
  localparam int SW = cnt_w(S);

  localparam logic [SW-1:0] S_LAST  = SW'(S - 1);
  localparam logic [XW-1:0] OX_LAST = XW'(OW - 1);
  localparam logic [YW-1:0] OY_LAST = YW'(OH - 1);
  localparam logic [CW-1:0] C_LAST  = CW'(C - 1);

  logic [CW-1:0] c_q, c_d;
  logic [YW-1:0] oy_q, oy_d;
  logic [XW-1:0] ox_q, ox_d;
  logic [SW-1:0] wy_q, wy_d, wx_q, wx_d;
  logic [OA-1:0] win_q, win_d;
  logic [IA-1:0] addr_q, addr_d;

  assign first_elem = (wy_q == '0) && (wx_q == '0);
  assign last_elem  = (wy_q == S_LAST) && (wx_q == S_LAST);
  assign last_win   = (c_q == C_LAST) && (oy_q == OY_LAST) && (ox_q == OX_LAST);
  assign input_addr = addr_q;
  assign win_addr   = win_q;

  always_comb begin
    c_d   = c_q;
    oy_d  = oy_q;
    ox_d  = ox_q;
    wy_d  = wy_q;
    wx_d  = wx_q;
    win_d = win_q;
    if (clear) begin
      c_d   = '0;
      oy_d  = '0;
      ox_d  = '0;
      wy_d  = '0;
      wx_d  = '0;
      win_d = '0;
    end else if (advance) begin
      if (wx_q != S_LAST) begin
        wx_d = wx_q + SW'(1);
      end else begin
        wx_d = '0;
        if (wy_q != S_LAST) begin
          wy_d = wy_q + SW'(1);
        end else begin
          wy_d  = '0;
          win_d = last_win ? '0 : win_q + OA'(1);
          if (ox_q != OX_LAST) begin
            ox_d = ox_q + XW'(1);
          end else begin
            ox_d = '0;
            if (oy_q != OY_LAST) begin
              oy_d = oy_q + YW'(1);
            end else begin
              oy_d = '0;
              c_d  = (c_q == C_LAST) ? '0 : c_q + CW'(1);
            end
          end
        end
      end
    end
    // Address of the element the next cycle will present; trailing rows/columns are unreachable.
    addr_d = IA'(32'(c_d) * (W * H) + (32'(oy_d) * S + 32'(wy_d)) * W
                 + 32'(ox_d) * S + 32'(wx_d));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_q    <= '0;
      oy_q   <= '0;
      ox_q   <= '0;
      wy_q   <= '0;
      wx_q   <= '0;
      win_q  <= '0;
      addr_q <= '0;
    end else begin
      c_q    <= c_d;
      oy_q   <= oy_d;
      ox_q   <= ox_d;
      wy_q   <= wy_d;
      wx_q   <= wx_d;
      win_q  <= win_d;
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/max_pool_2d.sv
// rtl/max_pool_2d.sv - streaming non-overlapping STRIDE x STRIDE signed max-pooling of a W x H x C volume.
// Define MAX_POOL_RELU_EN to clamp negative window maxima to zero before output (fused ReLU).
module max_pool_2d
  import max_pool_pkg::*;
#(
  parameter int INPUT_WIDTH    = 62,
  parameter int INPUT_HEIGHT   = 62,
  parameter int INPUT_CHANNELS = 30,
  parameter int STRIDE         = 2,
  localparam int OW = INPUT_WIDTH / STRIDE,
  localparam int OH = INPUT_HEIGHT / STRIDE,
  localparam int IA = cnt_w(INPUT_WIDTH * INPUT_HEIGHT * INPUT_CHANNELS),
  localparam int OA = cnt_w(OW * OH * INPUT_CHANNELS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] input_data,
  output logic [IA-1:0]            input_addr,
  input  logic                     input_valid,
  output logic signed [DATA_W-1:0] pooled_output,
  output logic [OA-1:0]            output_addr,
  output logic                     output_valid,
  output logic                     pool_done
);

  state_e        state_q, state_d;
  data_t         max_q, max_d;
  data_t         pooled_q, pooled_d;
  logic [OA-1:0] output_addr_q, output_addr_d;
  logic          output_valid_q, output_valid_d;
  logic          pool_done_q, pool_done_d;

  data_t         cand;
  data_t         result;
  logic          sample;
  logic          clear;
  logic          first_elem, last_elem, last_win;
  logic [OA-1:0] win_addr;

  assign sample = (state_q == ST_RUN) && enable && input_valid;
  assign clear  = (state_q != ST_RUN) || !enable;

  pool_addr_gen #(
    .W  (INPUT_WIDTH),
    .H  (INPUT_HEIGHT),
    .C  (INPUT_CHANNELS),
    .S  (STRIDE),
    .IA (IA),
    .OA (OA)
  ) u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .advance    (sample),
    .input_addr (input_addr),
    .win_addr   (win_addr),
    .first_elem (first_elem),
    .last_elem  (last_elem),
    .last_win   (last_win)
  );

  always_comb begin
    cand = (first_elem || (input_data > max_q)) ? input_data : max_q;
`ifdef MAX_POOL_RELU_EN
    result = cand[DATA_W-1] ? '0 : cand;
`else
    result = cand;
`endif
  end

  always_comb begin
    state_d        = state_q;
    max_d          = max_q;
    pooled_d       = pooled_q;
    output_addr_d  = output_addr_q;
    output_valid_d = 1'b0;
    pool_done_d    = (state_q == ST_DONE) && enable;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (sample) begin
          max_d = cand;
          if (last_elem) begin
            output_valid_d = 1'b1;
            pooled_d       = result;
            output_addr_d  = win_addr;
            if (last_win) state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (!enable) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      max_q          <= '0;
      pooled_q       <= '0;
      output_addr_q  <= '0;
      output_valid_q <= 1'b0;
      pool_done_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      max_q          <= max_d;
      pooled_q       <= pooled_d;
      output_addr_q  <= output_addr_d;
      output_valid_q <= output_valid_d;
      pool_done_q    <= pool_done_d;
    end
  end

  assign pooled_output = pooled_q;
  assign output_addr   = output_addr_q;
  assign output_valid  = output_valid_q;
  assign pool_done     = pool_done_q;

endmodule

// File: tb/tb_max_pool_2d.sv
// tb/tb_max_pool_2d.sv - runs a 4x4x1 and a 5x5x2 (stride 2) max_pool_2d side by side against a loop-based pooling model.
`timescale 1ns/1ps
module tb_max_pool_2d;

  typedef struct { int addr; int val; } wr_t;
  typedef struct { int mode; bit on_b; int idx; int addr; int val; } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset, enable, input_valid;
  logic signed [15:0] input_data_a, input_data_b, pooled_output_a, pooled_output_b;
  logic [3:0]         input_addr_a;
  logic [1:0]         output_addr_a;
  logic [5:0]         input_addr_b;
  logic [2:0]         output_addr_b;
  logic               output_valid_a, output_valid_b, pool_done_a, pool_done_b;

  logic signed [15:0] mem_a [16];
  logic signed [15:0] mem_b [64];

  assign input_data_a = mem_a[input_addr_a];
  assign input_data_b = mem_b[input_addr_b];

  max_pool_2d #(.INPUT_WIDTH(4), .INPUT_HEIGHT(4), .INPUT_CHANNELS(1), .STRIDE(2)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .input_data(input_data_a),
    .input_addr(input_addr_a), .input_valid(input_valid), .pooled_output(pooled_output_a),
    .output_addr(output_addr_a), .output_valid(output_valid_a), .pool_done(pool_done_a));

  max_pool_2d #(.INPUT_WIDTH(5), .INPUT_HEIGHT(5), .INPUT_CHANNELS(2), .STRIDE(2)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .input_data(input_data_b),
    .input_addr(input_addr_b), .input_valid(input_valid), .pooled_output(pooled_output_b),
    .output_addr(output_addr_b), .output_valid(output_valid_b), .pool_done(pool_done_b));

  int   n_checks = 0;
  int   n_fail   = 0;
  wr_t  got_a[$], got_b[$], exp_wr_a[$], exp_wr_b[$];
  int   exp_rd_a[$], exp_rd_b[$];
  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_in_addr_a"}, int'(input_addr_a), 0);
    check({tag, "_pooled_a"}, int'(pooled_output_a), 0);
    check({tag, "_out_addr_a"}, int'(output_addr_a), 0);
    check({tag, "_valid_a"}, int'(output_valid_a), 0);
    check({tag, "_done_a"}, int'(pool_done_a), 0);
    check({tag, "_in_addr_b"}, int'(input_addr_b), 0);
    check({tag, "_pooled_b"}, int'(pooled_output_b), 0);
    check({tag, "_out_addr_b"}, int'(output_addr_b), 0);
    check({tag, "_valid_b"}, int'(output_valid_b), 0);
    check({tag, "_done_b"}, int'(pool_done_b), 0);
  endtask

  // mode 0: ramp, 1: -(i+1), other: random; unused b words are poison maxima
  task automatic fill(input int mode);
    logic signed [15:0] v;
    for (int i = 0; i < 64; i++) begin
      case (mode)
        0:       v = 16'(i);
        1:       v = 16'(-(i + 1));
        default: v = 16'($urandom);
      endcase
      if (i < 16) mem_a[i] = v;
      mem_b[i] = (i < 50) ? v : 16'sh7fff;
    end
  endtask

  task automatic build_model(input bit b);
    int  w, c, ow, idx, v, m;
    wr_t wq[$];
    int  rq[$];
    w  = b ? 5 : 4;
    c  = b ? 2 : 1;
    ow = w / 2;
    for (int ch = 0; ch < c; ch++)
      for (int oy = 0; oy < ow; oy++)
        for (int ox = 0; ox < ow; ox++) begin
          m = -32768;
          for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++) begin
              idx = ch * w * w + (oy * 2 + dy) * w + ox * 2 + dx;
              rq.push_back(idx);
              v = b ? int'(mem_b[idx]) : int'(mem_a[idx]);
              if (v > m) m = v;
            end
`ifdef MAX_POOL_RELU_EN
          if (m < 0) m = 0;
`endif
          wq.push_back('{addr: ch * ow * ow + oy * ow + ox, val: m});
        end
    if (b) begin
      exp_wr_b = wq;
      exp_rd_b = rq;
    end else begin
      exp_wr_a = wq;
      exp_rd_a = rq;
    end
  endtask

  task automatic compare_writes(input string tag, input bit b);
    wr_t g[$], e[$];
    if (b) begin g = got_b; e = exp_wr_b; end
    else   begin g = got_a; e = exp_wr_a; end
    check({tag, "_nwrites"}, g.size(), e.size());
    for (int i = 0; i < e.size() && i < g.size(); i++) begin
      check($sformatf("%s_waddr%0d", tag, i), g[i].addr, e[i].addr);
      check($sformatf("%s_wval%0d", tag, i), g[i].val, e[i].val);
    end
  endtask

  task automatic check_table(input int mode);
    int act_addr, act_val;
    foreach (vecs[i]) begin
      if (vecs[i].mode == mode) begin
        act_addr = -1;
        act_val  = -99999;
        if (vecs[i].on_b && vecs[i].idx < got_b.size()) begin
          act_addr = got_b[vecs[i].idx].addr;
          act_val  = got_b[vecs[i].idx].val;
        end else if (!vecs[i].on_b && vecs[i].idx < got_a.size()) begin
          act_addr = got_a[vecs[i].idx].addr;
          act_val  = got_a[vecs[i].idx].val;
        end
        check($sformatf("tbl_m%0d_%s%0d_addr", mode, vecs[i].on_b ? "b" : "a", vecs[i].idx),
              act_addr, vecs[i].addr);
        check($sformatf("tbl_m%0d_%s%0d_val", mode, vecs[i].on_b ? "b" : "a", vecs[i].idx),
              act_val, vecs[i].val);
      end
    end
  endtask

  // Starts just after a negedge with both DUTs idle; abort_after < 0 means run to completion.
  task automatic do_run(input string tag, input int stall_at, input int stall_len, input int abort_after);
    int sa, sb, na, nb, stall_left, cyc, last_a, last_b, done_a, done_b, abort_cyc, late, trailing;
    bit aborted;
    build_model(1'b0);
    build_model(1'b1);
    got_a.delete();
    got_b.delete();
    na = exp_rd_a.size();
    nb = exp_rd_b.size();
    sa = 0; sb = 0; stall_left = stall_len; cyc = 0;
    last_a = -1; last_b = -1; done_a = -1; done_b = -1;
    abort_cyc = 0; late = 0; trailing = 0; aborted = 1'b0;
    enable = 1'b1;
    input_valid = 1'b1;
    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (output_valid_a) begin
        got_a.push_back('{addr: int'(output_addr_a), val: int'(pooled_output_a)});
        last_a = cyc;
        if (aborted) late++;
      end
      if (output_valid_b) begin
        got_b.push_back('{addr: int'(output_addr_b), val: int'(pooled_output_b)});
        last_b = cyc;
        if (aborted) late++;
      end
      if (pool_done_a && done_a < 0) done_a = cyc;
      if (pool_done_b && done_b < 0) done_b = cyc;
      if (aborted) begin
        if (pool_done_a || pool_done_b) late++;
        if (cyc >= abort_cyc + 8) break;
      end else begin
        if (done_a >= 0 && done_b >= 0) break;
        if (sa < na) check($sformatf("%s_rd_a%0d", tag, sa), int'(input_addr_a), exp_rd_a[sa]);
        if (sb < nb) begin
          check($sformatf("%s_rd_b%0d", tag, sb), int'(input_addr_b), exp_rd_b[sb]);
          if ((int'(input_addr_b) % 5 == 4) || ((int'(input_addr_b) % 25) / 5 == 4)) trailing++;
        end
        if (abort_after >= 0 && sa == abort_after) begin
          enable = 1'b0;
          aborted = 1'b1;
          abort_cyc = cyc;
        end else begin
          input_valid = !(sa == stall_at && stall_left > 0);
          if (!input_valid) stall_left--;
          else begin
            if (sa < na) sa++;
            if (sb < nb) sb++;
          end
        end
      end
    end
    check({tag, "_b_trailing_reads"}, trailing, 0);
    if (aborted) begin
      check({tag, "_late_activity"}, late, 0);
      check({tag, "_abort_nwr_a"}, got_a.size(), 1);
      check({tag, "_abort_nwr_b"}, got_b.size(), 1);
      if (got_a.size() > 0) check({tag, "_abort_val_a"}, got_a[0].val, exp_wr_a[0].val);
      if (got_b.size() > 0) check({tag, "_abort_val_b"}, got_b[0].val, exp_wr_b[0].val);
      check({tag, "_abort_addr_a"}, int'(input_addr_a), 0);
      check({tag, "_abort_addr_b"}, int'(input_addr_b), 0);
    end else begin
      compare_writes({tag, "_a"}, 1'b0);
      compare_writes({tag, "_b"}, 1'b1);
      check({tag, "_last_strobe_a"}, last_a, na + stall_len + 1);
      check({tag, "_last_strobe_b"}, last_b, nb + stall_len + 1);
      check({tag, "_done_rise_a"}, done_a, last_a + 1);
      check({tag, "_done_rise_b"}, done_b, last_b + 1);
      check({tag, "_done_held_a"}, int'(pool_done_a), 1);
      enable = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check({tag, "_done_fall_a"}, int'(pool_done_a), 0);
      check({tag, "_done_fall_b"}, int'(pool_done_b), 0);
    end
  endtask

  task automatic add_vec(input int mode, input bit on_b, input int idx, input int addr, input int val);
    vecs.push_back('{mode: mode, on_b: on_b, idx: idx, addr: addr, val: val});
  endtask

  initial begin
    add_vec(0, 0, 0, 0, 5);   add_vec(0, 0, 1, 1, 7);
    add_vec(0, 0, 2, 2, 13);  add_vec(0, 0, 3, 3, 15);
    add_vec(0, 1, 0, 0, 6);   add_vec(0, 1, 1, 1, 8);
    add_vec(0, 1, 2, 2, 16);  add_vec(0, 1, 3, 3, 18);
    add_vec(0, 1, 4, 4, 31);  add_vec(0, 1, 5, 5, 33);
    add_vec(0, 1, 6, 6, 41);  add_vec(0, 1, 7, 7, 43);
`ifdef MAX_POOL_RELU_EN
    add_vec(1, 0, 0, 0, 0);   add_vec(1, 0, 1, 1, 0);
    add_vec(1, 0, 2, 2, 0);   add_vec(1, 0, 3, 3, 0);
`else
    add_vec(1, 0, 0, 0, -1);  add_vec(1, 0, 1, 1, -3);
    add_vec(1, 0, 2, 2, -9);  add_vec(1, 0, 3, 3, -11);
`endif

    reset = 1'b0;
    enable = 1'b0;
    input_valid = 1'b0;
    fill(0);
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    reset = 1'b1;
    @(negedge clk);

    fill(0);
    do_run("ramp", 99, 0, -1);
    check_table(0);

    fill(1);
    do_run("neg", 99, 0, -1);
    check_table(1);

    fill(0);
    do_run("stall", 5, 3, -1);
    check_table(0);

    fill(0);
    do_run("abort", 99, 0, 6);
    do_run("rerun", 99, 0, -1);
    check_table(0);

    fill(0);
    enable = 1'b1;
    input_valid = 1'b1;
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1 check_zero("async_rst");
    enable = 1'b0;
    @(negedge clk);
    check_zero("rst_held");
    reset = 1'b1;
    @(negedge clk);
    fill(2);
    do_run("after_rst", 99, 0, -1);

    for (int r = 0; r < 3; r++) begin
      fill(2);
      do_run($sformatf("rnd%0d", r), int'($urandom_range(1, 14)), int'($urandom_range(1, 4)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/max_pool_2d.md
# max_pool_2d

Streaming 2-D max-pooling layer of the CNN pipeline, between the convolution feature-map memory and the fully-connected layer's input memory. It walks every non-overlapping STRIDE×STRIDE window of every channel through a combinational-read memory port and reduces each window to its signed maximum. Each result is written out through an address/valid port, and a done level is raised when the whole volume is pooled.

## Interface
- INPUT_WIDTH, 62: feature-map width W
- INPUT_HEIGHT, 62: feature-map height H
- INPUT_CHANNELS, 30: channel count C
- STRIDE, 2: window side and step (window = stride, no overlap)
- Derived: OW = W/STRIDE, OH = H/STRIDE (floor); IA = $clog2(W*H*C); OA = $clog2(OW*OH*C)

Reset is asynchronous and active-low; the port keeps the codebase name `reset`.

- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  run request; level-sensitive
- input_data  in  16 signed  memory word at input_addr, same cycle (combinational read)
- input_addr  out  IA  read address = c*W*H + y*W + x
- input_valid  in  1  input_data usable this cycle; low = stall
- pooled_output  out  16 signed  window maximum
- output_addr  out  OA  write address = c*OW*OH + oy*OW + ox
- output_valid  out  1  one-cycle write strobe for pooled_output/output_addr
- pool_done  out  1  whole volume pooled; held until enable falls

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: all counters zero. Enable high moves the FSM to RUN.
- RUN: traversal order is channel-major, then oy, then ox, then row-major inside the window.
  - Each cycle with input_valid=1 samples one element and advances.
  - input_valid=0 holds the address and all counters.
- First element of a window loads the running max. Later elements replace it only when strictly greater (signed 16-bit compare).
- Trailing rows/columns beyond OH*STRIDE / OW*STRIDE are never read.
- After the last element of the last window the FSM enters DONE. DONE holds pool_done=1 while enable=1.
- Enable low in DONE returns the FSM to IDLE.
- Enable low during RUN aborts: FSM to IDLE, counters cleared, no further output_valid.
- Reset values: input_addr 0, pooled_output 0, output_addr 0, output_valid 0, pool_done 0, FSM IDLE.

## Timing
- input_addr is registered and presents the next element each sampled cycle. Its first value (0) is valid in the first RUN cycle.
- output_valid pulses exactly one cycle, in the cycle after the window's last element is sampled. pooled_output and output_addr are stable in that cycle.
- The next window's reads proceed without a bubble, overlapping the write.
- Throughput: one element per cycle when input_valid stays high.
- Total run = OW*OH*C*STRIDE² sampled cycles. pool_done rises in the cycle after the final output_valid.
- Async reset mid-run forces reset values immediately; operation resumes only via IDLE.

## Configuration
- MAX_POOL_RELU_EN defined: each window result is clamped to 0 if negative before output (fused ReLU).
- MAX_POOL_RELU_EN undefined: the raw signed maximum is output.

## Structure
- Package max_pool_pkg: DATA_W=16, signed data typedef, FSM state enum.
- One sub-module, pool_addr_gen: the c/oy/ox/window counters producing input_addr, output_addr and last-element/last-window flags.
- Top level: comparator, FSM, output registers.

## Test plan
- W=H=4, C=1, S=2, memory = 0..15 row-major, input_valid=1.
  - Expect writes (addr,val) (0,5),(1,7),(2,13),(3,15).
  - Expect 16 read cycles, pool_done one cycle after the last strobe.
- Same geometry, memory = -(i+1) (values -1..-16).
  - Expect -1,-3,-9,-11 without MAX_POOL_RELU_EN.
  - Expect all 0 with MAX_POOL_RELU_EN.
- W=H=5, C=2, memory = 0..49: expect 8 writes.
  - Channel 0: 6,8,16,18 at addrs 0..3.
  - Channel 1: 31,33,41,43 at addrs 4..7.
  - Row 4 and column 4 are never addressed.
- Ramp test with input_valid low for 3 cycles mid-window: identical results, completion delayed by exactly 3 cycles.
- Enable dropped after 6 samples:
  - No strobe after the drop, pool_done stays 0.
  - Re-enable restarts from addr 0 and produces the full correct result.
- Reset asserted mid-run: all outputs read 0 while reset is low; the subsequent run is correct.
